// File: rtl/gsim_host_pkg.sv
// Shared constants and state encoding for the Gauss-Seidel host interface.
package gsim_host_pkg;

  localparam int N       = 16;
  localparam int B_W     = 16;
  localparam int X_W     = 32;
  localparam int TIMEOUT = 2047;

  localparam int IDX_W = 4;
  localparam int TMR_W = 11;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ABORT = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

endpackage

// File: rtl/gsim_vec_buf.sv
// N-entry register file: one write port, one registered read port.
module gsim_vec_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  // Storage write; contents need no reset because every entry is rewritten before use.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read so the caller presents the address one cycle ahead.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gsim_host.sv
// Host side of the solver link: buffer b, burst it to the solver, capture x, drain x.
module gsim_host
  import gsim_host_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_s_valid,
  output logic           o_s_ready,
  input  logic [B_W-1:0] i_s_data,
  output logic           o_in_en,
  output logic [B_W-1:0] o_b_in,
  input  logic           i_out_valid,
  input  logic [X_W-1:0] i_x_out,
  output logic           o_m_valid,
  input  logic           i_m_ready,
  output logic [X_W-1:0] o_m_data,
  output logic           o_m_last,
  output logic           o_busy,
  output logic           o_timeout_err,
  output logic           o_proto_err
);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic [TMR_W-1:0]   r_timer;
  logic               r_cap_en;
  logic               r_timeout_err;
  logic               r_proto_err;

  logic               w_idx_last;
  logic               w_timeout_hit;
  logic               w_proto_hit;
  logic               w_s_ready;
  logic               w_in_en;
  logic               w_m_valid;
  logic               w_b_wr_en;
  logic               w_x_wr_en;
  logic [IDX_W-1:0]   w_b_rd_addr;
  logic [IDX_W-1:0]   w_x_rd_addr;
  logic [B_W-1:0]     w_b_rd_data;
  logic [X_W-1:0]     w_x_rd_data;

  assign w_idx_last    = (r_idx == IDX_LAST);
  assign w_timeout_hit = (r_state == S_WAIT) && !i_out_valid && (r_timer == TMR_ABORT);
  assign w_proto_hit   = i_out_valid && (r_state != S_WAIT) && (r_state != S_CAPTURE);

  gsim_vec_buf #(.W(B_W), .DEPTH(N), .AW(IDX_W)) u_bbuf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_b_wr_en),
    .i_wr_addr (r_idx),
    .i_wr_data (i_s_data),
    .i_rd_addr (w_b_rd_addr),
    .o_rd_data (w_b_rd_data)
  );

  gsim_vec_buf #(.W(X_W), .DEPTH(N), .AW(IDX_W)) u_xbuf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_x_wr_en),
    .i_wr_addr (r_idx),
    .i_wr_data (i_x_out),
    .i_rd_addr (w_x_rd_addr),
    .o_rd_data (w_x_rd_data)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, index sequencing, buffer strobes and read-ahead addresses.
  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    w_s_ready    = 1'b0;
    w_in_en      = 1'b0;
    w_m_valid    = 1'b0;
    w_b_wr_en    = 1'b0;
    w_x_wr_en    = 1'b0;
    w_b_rd_addr  = '0;
    w_x_rd_addr  = '0;
    case (r_state)
      S_IDLE: begin
        w_idx_next   = '0;
        w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_s_ready = 1'b1;
        if (i_s_valid) begin
          w_b_wr_en = 1'b1;
          if (w_idx_last) begin
            w_idx_next   = '0;
            w_next_state = S_SEND;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      S_SEND: begin
        w_in_en     = 1'b1;
        w_b_rd_addr = r_idx + IDX_W'(1);
        if (w_idx_last) begin
          w_idx_next   = '0;
          w_next_state = S_WAIT;
        end else begin
          w_idx_next = r_idx + IDX_W'(1);
        end
      end
      S_WAIT: begin
        w_idx_next = '0;
        if (i_out_valid) begin
          w_next_state = S_CAPTURE;
        end else if (w_timeout_hit) begin
          w_next_state = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (r_cap_en) begin
          w_x_wr_en = 1'b1;
          if (w_idx_last) begin
            w_idx_next   = '0;
            w_next_state = S_DRAIN;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        w_m_valid   = 1'b1;
        w_x_rd_addr = r_idx;
        if (i_m_ready) begin
          w_x_rd_addr = r_idx + IDX_W'(1);
          if (w_idx_last) begin
            w_idx_next   = '0;
            w_next_state = S_IDLE;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_idx_next   = '0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Index, WAIT timer and the one-cycle delayed capture enable.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_idx    <= '0;
      r_timer  <= '0;
      r_cap_en <= 1'b0;
    end else begin
      r_idx    <= w_idx_next;
      r_cap_en <= i_out_valid;
      if (r_state == S_WAIT) begin
        if (r_timer != TMR_MAX) begin
          r_timer <= r_timer + TMR_W'(1);
        end
      end else begin
        r_timer <= '0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_timeout_err <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end
      if (w_proto_hit) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign o_s_ready     = w_s_ready;
  assign o_in_en       = w_in_en;
  assign o_b_in        = w_in_en ? w_b_rd_data : '0;
  assign o_m_valid     = w_m_valid;
  assign o_m_data      = w_m_valid ? w_x_rd_data : '0;
  assign o_m_last      = w_m_valid && w_idx_last;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_gsim_host.sv
// Transaction-level bench for gsim_host: scenario table plus randomized runs against a stream model.
module tb_gsim_host;
  import gsim_host_pkg::*;

  localparam int BUDGET = 4000;

  typedef struct {
    string name;
    int    gapMode;
    int    readyMode;
    int    delay;
    bit    fixedData;
    bit    noSolver;
    bit    protoPulse;
    bit    resetMid;
    bit    expTimeoutErr;
    bit    expProtoErr;
  } txn_t;

  logic           clk = 1'b0;
  logic           resetN;
  logic           sValid;
  logic           sReady;
  logic [B_W-1:0] sData;
  logic           inEn;
  logic [B_W-1:0] bIn;
  logic           outValid;
  logic [X_W-1:0] xOut;
  logic           mValid;
  logic           mReady;
  logic [X_W-1:0] mData;
  logic           mLast;
  logic           busy;
  logic           timeoutErr;
  logic           protoErr;

  int checks = 0;
  int errors = 0;

  logic [B_W-1:0] bVec [N];
  logic [X_W-1:0] xVec [N];
  bit             expTo;
  bit             expProto;
  txn_t           vecs [9];

  gsim_host dut (
    .i_clk         (clk),
    .i_reset       (resetN),
    .i_s_valid     (sValid),
    .o_s_ready     (sReady),
    .i_s_data      (sData),
    .o_in_en       (inEn),
    .o_b_in        (bIn),
    .i_out_valid   (outValid),
    .i_x_out       (xOut),
    .o_m_valid     (mValid),
    .i_m_ready     (mReady),
    .o_m_data      (mData),
    .o_m_last      (mLast),
    .o_busy        (busy),
    .o_timeout_err (timeoutErr),
    .o_proto_err   (protoErr)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // One transaction starting in an IDLE cycle; drives source, solver and sink, checks every cycle.
  task automatic applyStimulus(input txn_t t);
    int c, bIdx, outIdx, lastHs, ovStart;
    bit haveLast, ovSet, pulsed, done, protoNext;
    bit expSReady, expInEn, expMValid, expMLast, sv, mr, ov;
    logic [B_W-1:0] expBIn;
    logic [X_W-1:0] expMData;
    for (int k = 0; k < N; k++) begin
      bVec[k] = t.fixedData ? B_W'(k + 1) : B_W'($urandom);
      xVec[k] = t.fixedData ? X_W'(32'h0001_0000 * (k + 1)) : X_W'($urandom);
    end
    c = 0; bIdx = 0; outIdx = 0; lastHs = 0; ovStart = 0;
    haveLast = 0; ovSet = 0; pulsed = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (c > BUDGET) begin
        checks++;
        errors++;
        $display("[TB] FAIL budget %s: got %0d cycles, want <= %0d", t.name, c, BUDGET);
        break;
      end
      expSReady = (c >= 1) && (bIdx < N);
      expInEn   = haveLast && (c > lastHs) && (c <= lastHs + N);
      expBIn    = expInEn ? bVec[c - lastHs - 1] : '0;
      expMValid = ovSet && (c >= ovStart + N + 1) && (outIdx < N);
      expMData  = expMValid ? xVec[outIdx] : '0;
      expMLast  = expMValid && (outIdx == N - 1);
      checkOutput("s_ready", sReady, expSReady);
      checkOutput("in_en", inEn, expInEn);
      checkOutput("b_in", bIn, expBIn);
      checkOutput("m_valid", mValid, expMValid);
      checkOutput("m_data", mData, expMData);
      checkOutput("m_last", mLast, expMLast);
      checkOutput("busy", busy, c >= 1);
      checkOutput("timeout_err", timeoutErr, expTo);
      checkOutput("proto_err", protoErr, expProto);

      resetN = 1'b1;
      case (t.gapMode)
        0:       sv = 1'b1;
        1:       sv = (c % 2 == 1);
        default: sv = 1'($urandom_range(0, 1));
      endcase
      sValid = sv;
      sData  = (bIdx < N) ? bVec[bIdx] : B_W'($urandom);
      ov = ovSet && (c >= ovStart) && (c < ovStart + N);
      protoNext = 1'b0;
      if (t.protoPulse && !pulsed && (c >= 1) && (bIdx == 5)) begin
        ov = 1'b1;
        pulsed = 1'b1;
        protoNext = 1'b1;
      end
      xOut = (ovSet && (c > ovStart) && (c <= ovStart + N)) ? xVec[c - ovStart - 1] : X_W'($urandom);
      case (t.readyMode)
        0:       mr = 1'b1;
        1:       mr = (c % 3 == 0);
        default: mr = 1'($urandom_range(0, 1));
      endcase
      mReady = mr;
      if (t.resetMid && ovSet && (c == ovStart + 8)) begin
        resetN = 1'b0;
        ov = 1'b0;
      end
      outValid = ov;

      if (!resetN) begin
        expTo = 1'b0;
        expProto = 1'b0;
        done = 1'b1;
      end else begin
        if (protoNext) expProto = 1'b1;
        if (sv && expSReady) begin
          bIdx++;
          if (bIdx == N) begin
            haveLast = 1'b1;
            lastHs = c;
            if (!t.noSolver) begin
              ovSet = 1'b1;
              ovStart = c + N + t.delay;
            end
          end
        end
        if (expMValid && mr) begin
          outIdx++;
          if (outIdx == N) done = 1'b1;
        end
        if (t.noSolver && haveLast && (c == lastHs + N + TIMEOUT)) begin
          expTo = 1'b1;
          done = 1'b1;
        end
      end
      c++;
    end
    @(posedge clk);
    #1;
    checkOutput({t.name, " sticky timeout_err"}, timeoutErr, t.expTimeoutErr);
    checkOutput({t.name, " sticky proto_err"}, protoErr, t.expProtoErr);
  endtask

  // Test sequence: reset, scenario table, mid-capture reset, randomized transactions.
  initial begin
    txn_t r;
    //         name           gap rdy delay fix noSol proto rstMid expTo expProto
    vecs[0] = '{"basic",       0,  0,  40,   1,  0,    0,    0,     0,    0};
    vecs[1] = '{"upstream gap",1,  0,  40,   0,  0,    0,    0,     0,    0};
    vecs[2] = '{"backpressure",0,  1,  5,    1,  0,    0,    0,     0,    0};
    vecs[3] = '{"early solver",2,  2,  1,    0,  0,    0,    0,     0,    0};
    vecs[4] = '{"late solver", 0,  0,  TIMEOUT, 0, 0,  0,    0,     0,    0};
    vecs[5] = '{"timeout",     0,  0,  0,    0,  1,    0,    0,     1,    0};
    vecs[6] = '{"after tmo",   0,  0,  12,   1,  0,    0,    0,     1,    0};
    vecs[7] = '{"proto pulse", 0,  0,  20,   1,  0,    1,    0,     1,    1};
    vecs[8] = '{"random mix",  2,  2,  17,   0,  0,    0,    0,     1,    1};

    resetN = 1'b0; sValid = 1'b0; sData = '0; outValid = 1'b0; xOut = '0; mReady = 1'b0;
    expTo = 1'b0; expProto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset s_ready", sReady, 1'b0);
      checkOutput("reset in_en", inEn, 1'b0);
      checkOutput("reset b_in", bIn, '0);
      checkOutput("reset m_valid", mValid, 1'b0);
      checkOutput("reset m_data", mData, '0);
      checkOutput("reset m_last", mLast, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset timeout_err", timeoutErr, 1'b0);
      checkOutput("reset proto_err", protoErr, 1'b0);
    end

    for (int i = 0; i < 9; i++) begin
      $display("[TB] scenario %s", vecs[i].name);
      applyStimulus(vecs[i]);
    end

    $display("[TB] scenario reset mid-capture");
    r = '{"reset mid", 0, 0, 30, 1, 0, 1, 1, 0, 0};
    applyStimulus(r);
    r = '{"post reset", 1, 1, 25, 1, 0, 0, 0, 0, 0};
    applyStimulus(r);

    for (int i = 0; i < 5; i++) begin
      r = '{"random", 2, 2, $urandom_range(1, 60), 0, 0, 0, 0, 0, 0};
      applyStimulus(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
